// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control symbols, serializer states and slot-count helpers
package tmds_pkg;
   localparam logic [9:0] CTL_00 = 10'b1101010100;
   localparam logic [9:0] CTL_01 = 10'b0010101011;
   localparam logic [9:0] CTL_10 = 10'b0101010100;
   localparam logic [9:0] CTL_11 = 10'b1010101011;
   localparam logic [9:0] CLK_PATTERN_10B = 10'b1111100000;
   typedef enum logic [1:0] {DISABLED, PRIME, RUN, DRAIN} state_e;
   function automatic int slots(input int word_w, input int bits);
      return word_w / bits;
   endfunction
   function automatic int phase_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/tmds_lane_shifter.sv
// tmds_lane_shifter: parallel-load shift register emitting B bits per clock, LSB first
module tmds_lane_shifter #(
   parameter int W = 10,
   parameter int B = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   output logic [B-1:0] ser_o
);
   logic [W-1:0] sh_q, sh_d;
   always_comb sh_d = clr_i ? '0 : load_i ? data_i : sh_q >> B;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sh_q <= '0;
      else sh_q <= sh_d;
   assign ser_o = sh_q[B-1:0];
endmodule

// File: rtl/tmds_serializer.sv
// tmds_serializer: buffered multi-lane TMDS serializer with idle insertion and graceful enable
module tmds_serializer
   import tmds_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int WORD_W = 10,
   parameter int BITS_PER_CLK = 1,
   parameter logic [WORD_W-1:0] IDLE_WORD = CTL_00,
   parameter logic [WORD_W-1:0] CLK_PATTERN = CLK_PATTERN_10B
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable_i,
   input  logic [NUM_CH*WORD_W-1:0]       word_i,
   input  logic                           word_valid_i,
   output logic                           word_ready_o,
   output logic [NUM_CH*BITS_PER_CLK-1:0] ser_o,
   output logic [BITS_PER_CLK-1:0]        ser_clk_o,
   output logic                           load_o,
   output logic                           running_o,
   output logic                           underflow_o,
   input  logic                           underflow_clr_i
);
   localparam int SLOTS = slots(WORD_W, BITS_PER_CLK);
   localparam int PW = phase_w(SLOTS);
   localparam int LW = NUM_CH * WORD_W;
   localparam logic [PW-1:0] LAST = PW'(SLOTS - 1);
   state_e state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [LW-1:0] hold_q, hold_d, src;
   logic hold_full_q, hold_full_d, under_q, under_d, load_q;
   logic boundary, prime_load, hs, active, shift_load, shift_clr, under_set;
   assign boundary = state_q == RUN && phase_q == LAST;
   assign prime_load = state_q == PRIME && enable_i && hold_full_q;
   assign active = state_q == RUN || state_q == DRAIN;
   assign word_ready_o = !hold_full_q || boundary;
   assign hs = word_valid_i && word_ready_o;
   assign shift_load = prime_load || boundary;
   assign shift_clr = state_d == DISABLED || state_d == PRIME;
   assign under_set = boundary && !hold_full_q && !word_valid_i;
   assign src = hold_full_q ? hold_q : word_valid_i ? word_i : {NUM_CH{IDLE_WORD}};
   always_comb begin
      state_d = state_q;
      case (state_q)
         DISABLED: state_d = enable_i ? PRIME : DISABLED;
         PRIME:    state_d = !enable_i ? DISABLED : hold_full_q ? RUN : PRIME;
         RUN:      state_d = enable_i ? RUN : DRAIN;
         DRAIN:    state_d = (phase_q == LAST) ? DISABLED : DRAIN;
         default:  state_d = DISABLED;
      endcase
   end
   // a bypassed word at the boundary leaves the hold empty
   always_comb begin
      phase_d = (active && phase_q != LAST) ? phase_q + 1'b1 : '0;
      hold_full_d = boundary ? (hold_full_q && hs) : prime_load ? 1'b0 : (hold_full_q || hs);
      hold_d = hs ? word_i : hold_q;
      under_d = under_set || (under_q && !underflow_clr_i);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= DISABLED;
         phase_q <= '0;
         hold_q <= '0;
         hold_full_q <= 1'b0;
         under_q <= 1'b0;
         load_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         hold_q <= hold_d;
         hold_full_q <= hold_full_d;
         under_q <= under_d;
         load_q <= shift_load;
      end
   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      tmds_lane_shifter #(.W(WORD_W), .B(BITS_PER_CLK)) u_sh (
         .clk(clk),
         .rst_n(rst_n),
         .clr_i(shift_clr),
         .load_i(shift_load),
         .data_i(src[k*WORD_W +: WORD_W]),
         .ser_o(ser_o[k*BITS_PER_CLK +: BITS_PER_CLK])
      );
   end
   tmds_lane_shifter #(.W(WORD_W), .B(BITS_PER_CLK)) u_clk_sh (
      .clk(clk),
      .rst_n(rst_n),
      .clr_i(shift_clr),
      .load_i(shift_load),
      .data_i(CLK_PATTERN),
      .ser_o(ser_clk_o)
   );
   assign load_o = load_q;
   assign running_o = state_q == RUN;
   assign underflow_o = under_q;
endmodule

// File: tb/tb_tmds_serializer.sv
// tb_tmds_serializer: directed checks of SDR and DDR serializer instances
module tb_tmds_serializer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [29:0] word = '0;
   logic clr = 1'b0;
   logic a_en = 1'b0, a_valid = 1'b0, b_en = 1'b0, b_valid = 1'b0;
   logic a_ready, a_load, a_run, a_under, b_ready, b_load, b_run, b_under;
   logic [2:0] a_ser;
   logic [0:0] a_clk;
   logic [5:0] b_ser;
   logic [1:0] b_clk;
   int total = 0, bad = 0;
   localparam logic [29:0] W0 = {10'h3FF, 10'h155, 10'h2AB};
   localparam logic [29:0] W1 = {10'h07A, 10'h2CC, 10'h1E1};
   logic [9:0] idle = 10'b1101010100;
   logic [9:0] clkpat = 10'b1111100000;
   logic [1:0] pairs [5] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
   logic [1:0] cpairs [5] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b11};

   always #5 clk = ~clk;

   tmds_serializer u_a (
      .clk(clk), .rst_n(rst_n), .enable_i(a_en), .word_i(word), .word_valid_i(a_valid),
      .word_ready_o(a_ready), .ser_o(a_ser), .ser_clk_o(a_clk), .load_o(a_load),
      .running_o(a_run), .underflow_o(a_under), .underflow_clr_i(clr)
   );
   tmds_serializer #(.BITS_PER_CLK(2)) u_b (
      .clk(clk), .rst_n(rst_n), .enable_i(b_en), .word_i(word), .word_valid_i(b_valid),
      .word_ready_o(b_ready), .ser_o(b_ser), .ser_clk_o(b_clk), .load_o(b_load),
      .running_o(b_run), .underflow_o(b_under), .underflow_clr_i(clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      a_en = 0; a_valid = 0; b_en = 0; b_valid = 0; clr = 0; word = '0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   function automatic logic [2:0] bits3(input logic [29:0] w, input int i);
      return {w[20+i], w[10+i], w[i]};
   endfunction

   function automatic logic [29:0] gen(input int n);
      logic [9:0] l0, l1, l2;
      l0 = 10'(n * 97 + 1);
      l1 = 10'(n * 41 + 300);
      l2 = 10'(n * 51 + 7);
      return {l2, l1, l0};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic hs;
      logic [29:0] rec;
      int n, m, p, gap;
      logic seen;
      // reset values
      tick;
      check("rst_ser", a_ser, 0);
      check("rst_clk", a_clk, 0);
      check("rst_load", a_load, 0);
      check("rst_run", a_run, 0);
      check("rst_under", a_under, 0);
      check("rst_ready", a_ready, 1);
      do_reset;
      // first word, then underflow and clear behaviour
      a_en = 1; a_valid = 1; word = W0;
      tick;
      a_valid = 0;
      check("hold_full_ready", a_ready, 0);
      tick;
      for (int i = 0; i < 10; i++) begin
         check("w0_ser", a_ser, bits3(W0, i));
         check("w0_clk", a_clk, clkpat[i]);
         check("w0_load", a_load, i == 0);
         check("w0_run", a_run, 1);
         check("w0_under", a_under, 0);
         tick;
      end
      check("uf_load", a_load, 1);
      for (int i = 0; i < 10; i++) begin
         check("idle_ser", a_ser, {3{idle[i]}});
         check("idle_clk", a_clk, clkpat[i]);
         check("idle_under", a_under, i < 5);
         if (i == 2) begin a_valid = 1; word = W1; end
         if (i == 3) a_valid = 0;
         if (i == 4) clr = 1;
         if (i == 5) clr = 0;
         tick;
      end
      for (int i = 0; i < 10; i++) begin
         check("w1_ser", a_ser, bits3(W1, i));
         check("w1_load", a_load, i == 0);
         check("w1_under", a_under, 0);
         if (i == 9) clr = 1;
         tick;
      end
      clr = 0;
      check("uf_set_wins", a_under, 1);
      check("uf2_load", a_load, 1);
      check("uf2_ser0", a_ser, 3'b000);
      tick;
      check("uf2_ser1", a_ser, 3'b000);
      tick;
      check("uf2_ser2", a_ser, 3'b111);
      // continuous stream of 100 words
      do_reset;
      n = 0; m = 0; p = 0; gap = 0; seen = 0;
      a_en = 1; a_valid = 1; word = gen(0);
      for (int c = 0; c < 1500 && m < 100; c++) begin
         hs = a_valid && a_ready;
         tick;
         if (hs) begin
            n++;
            if (n < 100) word = gen(n);
            else a_valid = 0;
         end
         if (a_load) begin
            if (seen) check("stream_gap", gap, 10);
            seen = 1; gap = 0; p = 0;
         end
         if (seen) begin
            gap++;
            if (p < 10) begin
               rec[p] = a_ser[0]; rec[10+p] = a_ser[1]; rec[20+p] = a_ser[2];
               if (p == 9) begin
                  check("stream_word", rec, gen(m));
                  check("stream_under", a_under, 0);
                  m++;
               end
            end
            p++;
         end
      end
      check("stream_count", m, 100);
      // DDR instance
      do_reset;
      b_en = 1; b_valid = 1; word = W0;
      tick;
      tick;
      for (int i = 0; i < 15; i++) begin
         check("ddr_pair", b_ser[1:0], pairs[i%5]);
         check("ddr_clk", b_clk, cpairs[i%5]);
         check("ddr_load", b_load, i % 5 == 0);
         check("ddr_under", b_under, 0);
         tick;
      end
      // graceful disable mid-word, held word sent first on re-enable
      do_reset;
      a_en = 1; a_valid = 1; word = W0;
      tick;
      word = W1;
      tick;
      for (int i = 0; i < 10; i++) begin
         check("drain_ser", a_ser, bits3(W0, i));
         check("drain_run", a_run, i <= 3);
         if (i == 1) a_valid = 0;
         if (i == 3) a_en = 0;
         tick;
      end
      check("dis_ser", a_ser, 0);
      check("dis_clk", a_clk, 0);
      check("dis_run", a_run, 0);
      check("dis_ready", a_ready, 0);
      a_en = 1;
      tick;
      check("reprime_run", a_run, 0);
      check("reprime_load", a_load, 0);
      tick;
      check("reen_load", a_load, 1);
      for (int i = 0; i < 10; i++) begin
         check("reen_ser", a_ser, bits3(W1, i));
         check("reen_run", a_run, 1);
         tick;
      end
      // async reset mid-word
      do_reset;
      a_en = 1; a_valid = 1; word = W0;
      tick;
      a_valid = 0;
      tick;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin a_valid = 1; word = W1; end
         if (i == 2) a_valid = 0;
         tick;
      end
      check("mid_ser", a_ser, bits3(W0, 4));
      check("mid_ready", a_ready, 0);
      rst_n = 0;
      #1;
      check("arst_ser", a_ser, 0);
      check("arst_run", a_run, 0);
      check("arst_load", a_load, 0);
      check("arst_ready", a_ready, 1);
      tick;
      rst_n = 1;
      tick;
      check("post_run", a_run, 0);
      check("post_ser", a_ser, 0);
      a_valid = 1; word = W1;
      tick;
      a_valid = 0;
      tick;
      check("post_load", a_load, 1);
      for (int i = 0; i < 10; i++) begin
         check("post_ser_w", a_ser, bits3(W1, i));
         tick;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
